// File: rtl/educell_esmunit_acc.sv
// educell_esmunit_acc: ESM window accumulator with valid/ready window handoff.
// Define EDU_ESM_EARLY_HANDOFF_EN to close the window on the second detection event.
module educell_esmunit_acc #(
  parameter int AQMEAS_TH = 8,
  parameter int IDXW      = $clog2(AQMEAS_TH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 meas_valid,
  input  logic                 meas_bit,
  output logic                 meas_ready,
  input  logic                 flush,
  output logic                 esm_valid,
  input  logic                 esm_ready,
  output logic [AQMEAS_TH-1:0] esm_reg,
  output logic [IDXW-1:0]      wr_idx,
  output logic [IDXW:0]        esm_cnt
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(AQMEAS_TH - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW:0]   CNT_ONE  = (IDXW + 1)'(1);

  state_e                 state_q, state_d;
  logic [AQMEAS_TH-1:0]   esm_reg_q, esm_reg_d;
  logic [IDXW-1:0]        wr_idx_q, wr_idx_d;
  logic [IDXW:0]          esm_cnt_q, esm_cnt_d;

  logic accept;
  logic handoff;
  logic last;
  logic early;

  assign meas_ready = (state_q == COLLECT);
  assign esm_valid  = (state_q == HOLD);
  assign esm_reg    = esm_reg_q;
  assign wr_idx     = wr_idx_q;
  assign esm_cnt    = esm_cnt_q;

  // flush masks both beat and handoff so the case arms stay exclusive
  assign accept  = meas_valid & meas_ready & ~flush;
  assign handoff = esm_valid & esm_ready & ~flush;
  assign last    = (wr_idx_q == LAST_IDX);

`ifdef EDU_ESM_EARLY_HANDOFF_EN
  assign early = meas_bit & (esm_cnt_q == CNT_ONE);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    esm_reg_d = esm_reg_q;
    wr_idx_d  = wr_idx_q;
    esm_cnt_d = esm_cnt_q;
    unique case (1'b1)
      flush: begin
        state_d   = COLLECT;
        esm_reg_d = '0;
        wr_idx_d  = '0;
        esm_cnt_d = '0;
      end
      accept: begin
        esm_reg_d[wr_idx_q] = meas_bit;
        if (meas_bit) begin
          esm_cnt_d = esm_cnt_q + CNT_ONE;
        end
        // pointer parks on the closing position
        if (last || early) begin
          state_d = HOLD;
        end else begin
          wr_idx_d = wr_idx_q + IDX_ONE;
        end
      end
      handoff: begin
        state_d   = COLLECT;
        esm_reg_d = '0;
        wr_idx_d  = '0;
        esm_cnt_d = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      esm_reg_q <= '0;
      wr_idx_q  <= '0;
      esm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      esm_reg_q <= esm_reg_d;
      wr_idx_q  <= wr_idx_d;
      esm_cnt_q <= esm_cnt_d;
    end
  end

endmodule

// File: doc/educell_esmunit_acc.md
# educell_esmunit_acc

Error-syndrome-measurement (ESM) accumulator for one EDU cell. It collects one measurement bit per accepted beat into an `AQMEAS_TH`-wide window register and hands the completed window downstream over a valid/ready handshake. The downstream consumer is the EDU cell's first/second-set-index extraction logic. It is the producer side of the `esm_reg` interface: it writes the history that the index logic reads.

## Interface
Parameters:
- `AQMEAS_TH`, from `define.v`: window length, i.e. measurement rounds per window; must be ≥ 2.
- `IDXW`, `log2(AQMEAS_TH)`: width of the write pointer.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `meas_valid`  in  1  a measurement bit is offered.
- `meas_bit`  in  1  syndrome measurement result (1 = detection event).
- `meas_ready`  out  1  accumulator can accept a bit.
- `flush`  in  1  discard the current window (synchronous).
- `esm_valid`  out  1  `esm_reg` holds a completed window.
- `esm_ready`  in  1  downstream accepts the window.
- `esm_reg`  out  `AQMEAS_TH`  window; bit I = measurement of round I.
- `wr_idx`  out  `IDXW`  next bit position to be written.
- `esm_cnt`  out  `IDXW+1`  number of 1s accepted in the current window.

## Operation
- **Reset values:** `esm_reg`=0, `wr_idx`=0, `esm_cnt`=0, `esm_valid`=0, state=COLLECT; `meas_ready` is therefore 1.
- **FSM:** two states, COLLECT and HOLD.
- **COLLECT:**
  - `meas_ready`=1 and `esm_valid`=0.
  - A beat is accepted when `meas_valid` and `meas_ready` are both 1.
  - On an accepted beat: `esm_reg[wr_idx]` <= `meas_bit`, `wr_idx` <= `wr_idx`+1, and `esm_cnt` increments when `meas_bit`=1.
  - When the accepted beat has `wr_idx`=`AQMEAS_TH`-1, go to HOLD. `wr_idx` does not wrap and stays at `AQMEAS_TH`-1.
- **HOLD:**
  - `meas_ready`=0 and `esm_valid`=1.
  - `esm_reg`, `wr_idx` and `esm_cnt` are frozen.
  - When `esm_valid` and `esm_ready` are both 1, clear `esm_reg`, `wr_idx` and `esm_cnt` to 0 and go to COLLECT.
- **Flush:**
  - `flush`=1 in either state clears `esm_reg`, `wr_idx`, `esm_cnt` and `esm_valid` on the next edge and forces COLLECT.
  - Flush has priority over an accepted beat and over a handoff in the same cycle; that beat or window is dropped.
- **Counter rule:** `esm_cnt` never exceeds `AQMEAS_TH`, so `IDXW+1` bits are sufficient. No wrap-around is possible.
- **Positions not written** (early handoff only, see Configuration) remain 0.
- **`meas_bit` when not accepted:** ignored; no state change.

## Timing
- `meas_ready` and `esm_valid` are decoded combinationally from the state register only. There is no combinational path from any input to any output.
- **Write latency:** a bit accepted at edge N is visible on `esm_reg` and `esm_cnt` after edge N.
- **Completion:** `esm_valid` rises the cycle after the final beat is accepted.
- **Handoff:** in the handoff cycle `meas_ready` is 0, so no beat can be accepted. The first beat of the next window can be accepted in the cycle after handoff.
- **Throughput:** at most one window per `AQMEAS_TH`+1 cycles.
- **Asynchronous reset mid-window or mid-HOLD:** all state returns to the reset values immediately and the partial window is lost.

## Configuration
- **Macro:** `EDU_ESM_EARLY_HANDOFF_EN`.
- **Defined:**
  - In COLLECT, an accepted beat with `meas_bit`=1 while `esm_cnt`=1 (the second detection event) transitions to HOLD immediately.
  - `esm_reg` holds the bits written so far; higher positions are 0.
  - `wr_idx` holds the position of that second 1.
  - The full-window rule still applies if fewer than two 1s arrive.
- **Undefined:** the window always fills all `AQMEAS_TH` positions before HOLD.

## Test plan
Bench uses `AQMEAS_TH`=8.
1. **Reset:** `rst_n`=0 mid-window after 3 beats. Require `esm_reg`=0x00, `wr_idx`=0, `esm_cnt`=0, `esm_valid`=0 and `meas_ready`=1 immediately, without waiting for a clock edge.
2. **Full window:** stream bits 0,1,0,0,1,0,0,1 with `meas_valid` held high and the macro undefined. Require `esm_valid`=1 one cycle after the 8th beat, `esm_reg`=0x92, `esm_cnt`=3, `meas_ready`=0.
3. **Backpressure:** after scenario 2, hold `esm_ready`=0 for 5 cycles while offering `meas_valid`=1. Require `esm_reg` to stay 0x92 and no beat to be accepted. Then pulse `esm_ready`=1 for one cycle; require `esm_reg`=0x00 and `meas_ready`=1 on the following cycle.
4. **Flush priority:** `flush`=1 in the same cycle as an accepted beat with `meas_bit`=1 at `wr_idx`=4. Require `esm_reg`=0x00, `wr_idx`=0, `esm_cnt`=0 on the next cycle.
5. **Early handoff:** with `EDU_ESM_EARLY_HANDOFF_EN` defined, stream 0,0,1,0,1. Require HOLD after the 5th beat, `esm_reg`=0x14, `esm_cnt`=2, `wr_idx`=4. Repeat the stream with the macro undefined and require the accumulator to remain in COLLECT with `wr_idx`=5.
6. **Gapped input:** toggle `meas_valid` every other cycle across a full window. Require exactly 8 accepted beats before `esm_valid` rises, with bits landing at positions 0..7 in arrival order.
